// File: rtl/regfile_pkg.sv
// Shared defaults and read-source selection for the parameterised register file.
package regfile_pkg;

   localparam int DEF_WIDTH    = 32;
   localparam int DEF_DEPTH    = 32;
   localparam bit DEF_ZERO_REG = 1'b1;
   localparam bit DEF_BYPASS   = 1'b1;

   typedef enum logic [1:0] {
      SRC_STORE,
      SRC_PORT1,
      SRC_PORT2,
      SRC_ZERO
   } read_src_e;

   // Hardwired zero beats bypass, and port 2 beats port 1, mirroring the write priority.
   function automatic read_src_e read_src(input logic zero_hit,
                                          input logic hit1,
                                          input logic hit2);
      if (zero_hit)  return SRC_ZERO;
      else if (hit2) return SRC_PORT2;
      else if (hit1) return SRC_PORT1;
      else           return SRC_STORE;
   endfunction

endpackage

// File: rtl/register_word.sv
// One storage word: loads d on posedge clk when en is high, clears asynchronously on rst.
module register_word #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // NOTE: every word is reset because the file must read all-zero while reset is held;
   // a RAM macro without reset would not meet that.
   // NOTE: sequential state uses non-blocking assignment so all words update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/regfile_param.sv
// Two-read/two-write register file with optional hardwired r0, write-through bypass and
// a registered same-address write collision flag.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter bit ZERO_REG = DEF_ZERO_REG,
   parameter bit BYPASS   = DEF_BYPASS,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] ReadRegister1,
   input  logic [ADDR_W-1:0] ReadRegister2,
   output logic [WIDTH-1:0]  ReadData1,
   output logic [WIDTH-1:0]  ReadData2,
   input  logic [ADDR_W-1:0] WriteRegister1,
   input  logic [WIDTH-1:0]  WriteData1,
   input  logic              RegWrite1,
   input  logic [ADDR_W-1:0] WriteRegister2,
   input  logic [WIDTH-1:0]  WriteData2,
   input  logic              RegWrite2,
   output logic              WriteCollision
);

   logic [WIDTH-1:0] words  [DEPTH];
   logic [WIDTH-1:0] word_d [DEPTH];
   logic [DEPTH-1:0] word_en;

   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);
      localparam bit HARD_ZERO = ZERO_REG && (i == 0);

      logic hit1;
      logic hit2;

      assign hit1       = RegWrite1 && (WriteRegister1 == IDX);
      assign hit2       = RegWrite2 && (WriteRegister2 == IDX);
      assign word_en[i] = (hit1 || hit2) && !HARD_ZERO;
      assign word_d[i]  = hit2 ? WriteData2 : WriteData1;

      register_word #(.WIDTH(WIDTH)) u_word (
         .clk (Clk),
         .rst (Reset),
         .en  (word_en[i]),
         .d   (word_d[i]),
         .q   (words[i])
      );
   end

   function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
      logic zero_hit;
      logic hit1;
      logic hit2;
      zero_hit = ZERO_REG && (addr == '0);
      hit1     = BYPASS && RegWrite1 && (WriteRegister1 == addr);
      hit2     = BYPASS && RegWrite2 && (WriteRegister2 == addr);
      // NOTE: the default arm makes every source fully decoded, so no latch can be inferred.
      unique case (read_src(zero_hit, hit1, hit2))
         SRC_ZERO:  return '0;
         SRC_PORT1: return WriteData1;
         SRC_PORT2: return WriteData2;
         default:   return words[addr];
      endcase
   endfunction

   assign ReadData1 = read_port(ReadRegister1);
   assign ReadData2 = read_port(ReadRegister2);

   // A dual write to hardwired r0 is discarded, so it is not a collision.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         WriteCollision <= 1'b0;
      else
         WriteCollision <= RegWrite1 && RegWrite2 &&
                           (WriteRegister1 == WriteRegister2) &&
                           !(ZERO_REG && (WriteRegister1 == '0));
   end

endmodule

// File: tb/tb_regfile_param.sv
// Directed, table-driven bench for regfile_param: default, no-bypass and small instances.
module tb_regfile_param;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [4:0]  rr1 = '0, rr2 = '0, wr1 = '0, wr2 = '0;
   logic [31:0] wd1 = '0, wd2 = '0;
   logic        rw1 = 1'b0, rw2 = 1'b0;
   logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
   logic        coll, nb_coll;

   logic [1:0]  s_rr1 = '0, s_rr2 = '0, s_wr1 = '0, s_wr2 = '0;
   logic [7:0]  s_wd1 = '0, s_wd2 = '0;
   logic        s_rw1 = 1'b0, s_rw2 = 1'b0;
   logic [7:0]  s_rd1, s_rd2;
   logic        s_coll;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   regfile_param dut (
      .Clk(Clk), .Reset(Reset),
      .ReadRegister1(rr1), .ReadRegister2(rr2),
      .ReadData1(rd1), .ReadData2(rd2),
      .WriteRegister1(wr1), .WriteData1(wd1), .RegWrite1(rw1),
      .WriteRegister2(wr2), .WriteData2(wd2), .RegWrite2(rw2),
      .WriteCollision(coll)
   );

   regfile_param #(.BYPASS(1'b0)) dut_nb (
      .Clk(Clk), .Reset(Reset),
      .ReadRegister1(rr1), .ReadRegister2(rr2),
      .ReadData1(nb_rd1), .ReadData2(nb_rd2),
      .WriteRegister1(wr1), .WriteData1(wd1), .RegWrite1(rw1),
      .WriteRegister2(wr2), .WriteData2(wd2), .RegWrite2(rw2),
      .WriteCollision(nb_coll)
   );

   regfile_param #(.WIDTH(8), .DEPTH(4), .ZERO_REG(1'b0)) dut_s (
      .Clk(Clk), .Reset(Reset),
      .ReadRegister1(s_rr1), .ReadRegister2(s_rr2),
      .ReadData1(s_rd1), .ReadData2(s_rd2),
      .WriteRegister1(s_wr1), .WriteData1(s_wd1), .RegWrite1(s_rw1),
      .WriteRegister2(s_wr2), .WriteData2(s_wd2), .RegWrite2(s_rw2),
      .WriteCollision(s_coll)
   );

   typedef struct {
      logic        rw1;
      logic [4:0]  wr1;
      logic [31:0] wd1;
      logic        rw2;
      logic [4:0]  wr2;
      logic [31:0] wd2;
      logic [4:0]  rr1;
      logic [4:0]  rr2;
      logic [31:0] pre1;
      logic [31:0] pre2;
      logic [31:0] post1;
      logic [31:0] post2;
      logic        coll;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_writes();
      rw1 = 1'b0;
      rw2 = 1'b0;
      s_rw1 = 1'b0;
      s_rw2 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //         rw1   wr1    wd1          rw2   wr2    wd2      rr1    rr2    pre1     pre2     post1    post2    coll
      vecs[0] = '{1'b1, 5'd2,  32'd42,      1'b0, 5'd0,  32'h0,   5'd2,  5'd2,  32'd42,  32'd42,  32'd42,  32'd42,  1'b0};
      vecs[1] = '{1'b1, 5'd3,  32'd15,      1'b0, 5'd0,  32'h0,   5'd2,  5'd3,  32'd42,  32'd15,  32'd42,  32'd15,  1'b0};
      vecs[2] = '{1'b1, 5'd1,  32'h77,      1'b0, 5'd0,  32'h0,   5'd1,  5'd1,  32'h77,  32'h77,  32'h77,  32'h77,  1'b0};
      vecs[3] = '{1'b0, 5'd1,  32'hDEAD,    1'b0, 5'd1,  32'hDEAD,5'd1,  5'd2,  32'h77,  32'd42,  32'h77,  32'd42,  1'b0};
      vecs[4] = '{1'b1, 5'd5,  32'h11,      1'b1, 5'd5,  32'h22,  5'd5,  5'd5,  32'h22,  32'h22,  32'h22,  32'h22,  1'b1};
      vecs[5] = '{1'b1, 5'd0,  32'h11,      1'b1, 5'd0,  32'h22,  5'd0,  5'd5,  32'h0,   32'h22,  32'h0,   32'h22,  1'b0};
      vecs[6] = '{1'b1, 5'd6,  32'h66,      1'b1, 5'd8,  32'h88,  5'd6,  5'd8,  32'h66,  32'h88,  32'h66,  32'h88,  1'b0};
      vecs[7] = '{1'b0, 5'd0,  32'h0,       1'b1, 5'd10, 32'hA0,  5'd10, 5'd6,  32'hA0,  32'h66,  32'hA0,  32'h66,  1'b0};
      vecs[8] = '{1'b1, 5'd0,  32'h5,       1'b0, 5'd0,  32'h0,   5'd0,  5'd0,  32'h0,   32'h0,   32'h0,   32'h0,   1'b0};

      // Reset held from time zero: everything reads zero before any clock edge.
      #2;
      check("reset_rd1", rd1, 32'h0);
      check("reset_coll", {31'h0, coll}, 32'h0);
      check("reset_s_rd1", {24'h0, s_rd1}, 32'h0);
      @(negedge Clk);
      Reset = 1'b0;
      tick();

      foreach (vecs[i]) begin
         rw1 = vecs[i].rw1; wr1 = vecs[i].wr1; wd1 = vecs[i].wd1;
         rw2 = vecs[i].rw2; wr2 = vecs[i].wr2; wd2 = vecs[i].wd2;
         rr1 = vecs[i].rr1; rr2 = vecs[i].rr2;
         #1;
         check($sformatf("vec%0d_pre_rd1", i), rd1, vecs[i].pre1);
         check($sformatf("vec%0d_pre_rd2", i), rd2, vecs[i].pre2);
         tick();
         idle_writes();
         #1;
         check($sformatf("vec%0d_post_rd1", i), rd1, vecs[i].post1);
         check($sformatf("vec%0d_post_rd2", i), rd2, vecs[i].post2);
         check($sformatf("vec%0d_coll", i), {31'h0, coll}, {31'h0, vecs[i].coll});
         check($sformatf("vec%0d_nb_post_rd1", i), nb_rd1, vecs[i].post1);
         check($sformatf("vec%0d_nb_coll", i), {31'h0, nb_coll}, {31'h0, vecs[i].coll});
      end

      // Bypass versus stored value during a same-address write.
      rw1 = 1'b1; wr1 = 5'd7; wd1 = 32'h5;
      tick();
      idle_writes();
      rw1 = 1'b1; wr1 = 5'd7; wd1 = 32'h9; rr1 = 5'd7;
      #1;
      check("bypass_pre", rd1, 32'h9);
      check("nobypass_pre", nb_rd1, 32'h5);
      tick();
      idle_writes();
      #1;
      check("bypass_post", rd1, 32'h9);
      check("nobypass_post", nb_rd1, 32'h9);

      // Fill r1..r31 with their index, then reset mid-cycle.
      for (int a = 1; a < 32; a++) begin
         rw1 = 1'b1; wr1 = 5'(a); wd1 = 32'(a);
         tick();
      end
      idle_writes();
      rr1 = 5'd31; rr2 = 5'd17;
      #1;
      check("fill_r31", rd1, 32'd31);
      check("fill_r17", rd2, 32'd17);
      #2;
      Reset = 1'b1;
      for (int a = 0; a < 32; a++) begin
         rr1 = 5'(a); rr2 = 5'(31 - a);
         #1;
         check($sformatf("midreset_rd1_r%0d", a), rd1, 32'h0);
         check($sformatf("midreset_rd2_r%0d", 31 - a), rd2, 32'h0);
      end
      check("midreset_coll", {31'h0, coll}, 32'h0);
      rw1 = 1'b1; wr1 = 5'd4; wd1 = 32'h3; rr1 = 5'd4;
      #1;
      check("reset_bypass", rd1, 32'h3);
      tick();
      idle_writes();
      #1;
      check("reset_write_ignored", rd1, 32'h0);
      Reset = 1'b0;
      #1;
      check("release_r4_zero", rd1, 32'h0);
      rw1 = 1'b1; wr1 = 5'd4; wd1 = 32'h3;
      tick();
      idle_writes();
      #1;
      check("first_edge_write_r4", rd1, 32'h3);

      // Small instance: r0 is an ordinary register.
      s_rw1 = 1'b1; s_wr1 = 2'd0; s_wd1 = 8'hFF; s_rr1 = 2'd0;
      #1;
      check("s_r0_bypass", {24'h0, s_rd1}, 32'hFF);
      tick();
      idle_writes();
      #1;
      check("s_r0_stored", {24'h0, s_rd1}, 32'hFF);
      s_rw1 = 1'b1; s_wr1 = 2'd3; s_wd1 = 8'h3C;
      tick();
      idle_writes();
      s_rr2 = 2'd3;
      #1;
      check("s_r3", {24'h0, s_rd2}, 32'h3C);
      check("s_r0_kept", {24'h0, s_rd1}, 32'hFF);
      s_rw1 = 1'b1; s_wr1 = 2'd0; s_wd1 = 8'h11;
      s_rw2 = 1'b1; s_wr2 = 2'd0; s_wd2 = 8'h22;
      tick();
      idle_writes();
      #1;
      check("s_r0_coll", {31'h0, s_coll}, 32'h1);
      check("s_r0_port2_wins", {24'h0, s_rd1}, 32'h22);
      tick();
      check("s_coll_one_cycle", {31'h0, s_coll}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL expose parameters, one per line: name, default, meaning.
- WIDTH, 32, data bits per register.
- DEPTH, 32, number of registers; power of two, at least 2.
- ADDR_W, log2(DEPTH), address bits; derived, not overridden.
- ZERO_REG, 1, when 1 register 0 reads 0 and ignores writes.
- BYPASS, 1, when 1 a read of the register being written this cycle returns the write data.
REQ-002 SHALL expose ports, one per line: name, direction, width, meaning.
- Clk, in, 1, clock; registers update on posedge.
- Reset, in, 1, asynchronous, active-high; clears all registers.
- ReadRegister1, in, ADDR_W, read port 1 address.
- ReadRegister2, in, ADDR_W, read port 2 address.
- ReadData1, out, WIDTH, read port 1 data.
- ReadData2, out, WIDTH, read port 2 data.
- WriteRegister1, in, ADDR_W, write port 1 address.
- WriteData1, in, WIDTH, write port 1 data.
- RegWrite1, in, 1, write port 1 enable.
- WriteRegister2, in, ADDR_W, write port 2 address.
- WriteData2, in, WIDTH, write port 2 data.
- RegWrite2, in, 1, write port 2 enable.
- WriteCollision, out, 1, registered flag: both ports wrote the same address on the last edge.
REQ-003 SHALL use one clock (Clk) and one asynchronous, active-high reset (Reset); no other clocks or resets.

Function
REQ-004 SHALL write WriteDataN into register WriteRegisterN on posedge Clk when RegWriteN=1 and Reset=0.
REQ-005 SHALL leave every register unchanged when both RegWrite1 and RegWrite2 are 0.
REQ-006 SHALL write WriteData2 only when both ports are enabled for the same address; port 2 has priority.
REQ-007 SHALL update both registers on the same edge when both ports are enabled for different addresses.
REQ-008 SHALL set WriteCollision=1 for exactly one cycle after an edge with a same-address dual write, and 0 otherwise.
REQ-009 WriteCollision SHALL ignore collisions on register 0 when ZERO_REG=1.
REQ-010 SHALL make reads combinational with zero latency; ReadDataN reflects register contents at the addressed location.
REQ-011 SHALL, when ZERO_REG=1, return 0 on any read of address 0 and discard writes to address 0.
REQ-012 SHALL, when BYPASS=1 and a read address matches an enabled write address (not register 0 when ZERO_REG=1), return that port's write data before the edge.
REQ-013 SHALL apply the REQ-006 priority (port 2 wins) when bypass matches both write ports.
REQ-014 SHALL, when BYPASS=0, return the pre-edge stored value during a same-address write.
REQ-015 SHALL allow both read ports to address the same register at once, returning identical data.

Reset
REQ-016 SHALL, while Reset=1, hold all registers at 0 and WriteCollision at 0, independent of Clk.
REQ-017 SHALL ignore writes on any edge coinciding with Reset=1.
REQ-018 SHALL, when Reset is asserted between edges, make ReadData1/2 reflect 0 immediately, except for bypassed data per REQ-012.
REQ-019 SHALL accept writes on the first posedge after Reset deasserts.

Structure
REQ-020 SHALL place parameter defaults (WIDTH, DEPTH, ZERO_REG, BYPASS) in the shared package regfile_pkg.
REQ-021 SHALL build storage from DEPTH instances of sub-module register_word (WIDTH bits, enable, asynchronous reset).
REQ-022 SHALL keep address decode, priority mux and bypass logic in regfile_param.

Verification
REQ-023 SHALL cover: write 42 to r2 via port 1, then read r2 on both ports -> 42/42; then write 15 to r3 -> reads r2=42, r3=15.
REQ-024 SHALL cover: RegWrite1=RegWrite2=0, WriteData1=0xDEAD to r1 -> r1 still reads its prior value.
REQ-025 SHALL cover: same edge, port 1 writes 0x11 to r5 and port 2 writes 0x22 to r5 -> r5=0x22 and WriteCollision=1 for one cycle; same stimulus to r0 -> r0=0, WriteCollision=0.
REQ-026 SHALL cover: BYPASS=1, r7=0x5 stored, port 1 writes 0x9 to r7 with ReadRegister1=7 -> ReadData1=0x9 before the edge; BYPASS=0 -> 0x5 before the edge and 0x9 after.
REQ-027 SHALL cover: after writes fill r1..r31 with their index, assert Reset mid-cycle -> every read returns 0 immediately; a write of 0x3 to r4 on the first edge after release -> r4=3.
REQ-028 SHALL cover: WIDTH=8, DEPTH=4, ZERO_REG=0 -> write 0xFF to r0, read r0=0xFF; address 3 write/read works.
